// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchroniser, counter debounce,
// single-cycle press/release pulses and optional auto-repeat per channel.
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic               button_clk,
  input  logic               button_rst_n,
  input  logic [NUM_BTN-1:0] buttonIn,
  output logic [NUM_BTN-1:0] stableButton,
  output logic [NUM_BTN-1:0] pressPulse,
  output logic [NUM_BTN-1:0] releasePulse,
  output logic [NUM_BTN-1:0] repeatPulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (NUM_BTN < 1) begin : g_bad_num
    $error("button_conditioner: NUM_BTN must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 0) begin : g_bad_rdel
    $error("button_conditioner: REPEAT_DELAY must be >= 0");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_rper
    $error("button_conditioner: REPEAT_PERIOD must be >= 1");
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   stable_reg;
    logic                   stable_next;
    logic                   press_reg;
    logic                   release_reg;

    always_ff @(posedge button_clk or negedge button_rst_n) begin
      if (!button_rst_n) begin
        sync_reg <= '0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], buttonIn[gi]};
      end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // Any cycle agreeing with the accepted level restarts the count.
    always_comb begin
      stable_next = stable_reg;
      cnt_next    = '0;
      if (sync_out != stable_reg) begin
        if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_next = sync_out;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge button_clk or negedge button_rst_n) begin
      if (!button_rst_n) begin
        cnt_reg     <= '0;
        stable_reg  <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        cnt_reg     <= cnt_next;
        stable_reg  <= stable_next;
        press_reg   <= stable_next & ~stable_reg;
        release_reg <= ~stable_next & stable_reg;
      end
    end

    assign stableButton[gi] = stable_reg;
    assign pressPulse[gi]   = press_reg;
    assign releasePulse[gi] = release_reg;

    if (REPEAT_DELAY > 0) begin : g_rpt
      localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RPT_W   = $clog2(RPT_MAX + 1);

      logic [RPT_W-1:0] rcnt_reg;
      logic [RPT_W-1:0] rcnt_next;
      logic [RPT_W-1:0] rcnt_limit;
      logic             periodic_reg;
      logic             periodic_next;
      logic             rpt_reg;
      logic             rpt_next;

      // First repeat waits REPEAT_DELAY edges, later ones REPEAT_PERIOD; a
      // level change (press or release) restarts the schedule and masks a repeat.
      always_comb begin
        rcnt_next     = rcnt_reg;
        periodic_next = periodic_reg;
        rpt_next      = 1'b0;
        rcnt_limit    = periodic_reg ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
        if (stable_next != stable_reg) begin
          rcnt_next     = '0;
          periodic_next = 1'b0;
        end else if (stable_reg) begin
          if (rcnt_reg == rcnt_limit) begin
            rpt_next      = 1'b1;
            rcnt_next     = '0;
            periodic_next = 1'b1;
          end else begin
            rcnt_next = rcnt_reg + RPT_W'(1);
          end
        end
      end

      always_ff @(posedge button_clk or negedge button_rst_n) begin
        if (!button_rst_n) begin
          rcnt_reg     <= '0;
          periodic_reg <= 1'b0;
          rpt_reg      <= 1'b0;
        end else begin
          rcnt_reg     <= rcnt_next;
          periodic_reg <= periodic_next;
          rpt_reg      <= rpt_next;
        end
      end

      assign repeatPulse[gi] = rpt_reg;
    end else begin : g_no_rpt
      assign repeatPulse[gi] = 1'b0;
    end
  end

endmodule
